// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encodings and the
// instruction framing constants used by the top level and the assembler.
package program_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        COLLECT = 3'd3,
        WRITE   = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6,
        ERROR   = 3'd7
    } state_t;

    // Each instruction arrives as a 32-bit group, MSB first
    localparam int BYTES_PER_INSTR = 4;
    localparam int BYTE_CNT_W      = $clog2(BYTES_PER_INSTR);

endpackage

// File: rtl/program_loader_instr_assembler.sv
// Shifts incoming bytes into an instruction word and counts bytes within
// the current 4-byte group. Only the low INSTR_WIDTH bits are kept: the
// upper bits of the 32-bit group simply fall off the top of the register.
module instr_assembler
    import program_loader_pkg::*;
#(
    parameter int INSTR_WIDTH = 28
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   clear,
    input  logic                   shift_en,
    input  logic [7:0]             byte_in,
    output logic [INSTR_WIDTH-1:0] word,
    output logic                   last_byte
);

    logic [INSTR_WIDTH-1:0] shift_reg;
    logic [BYTE_CNT_W-1:0]  cnt_reg;

    // Shift register and per-instruction byte counter
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[INSTR_WIDTH-9:0], byte_in};
            cnt_reg   <= cnt_reg + BYTE_CNT_W'(1);
        end
    end

    assign word      = shift_reg;
    assign last_byte = shift_en && (cnt_reg == BYTE_CNT_W'(BYTES_PER_INSTR - 1));

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a 16-bit word count followed by 4-byte
// instructions over a valid/ready byte stream and writes them to program
// memory from address 0 while holding the CPU in reset.
// Optional macro PROGRAM_LOADER_CHECKSUM_EN adds a trailing modulo-256
// checksum byte covering the length and instruction bytes.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int INSTR_WIDTH = 28,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   iStart,
    input  logic                   iByteValid,
    input  logic [7:0]             iByte,
    output logic                   oByteReady,
    output logic                   oWriteEnable,
    output logic [ADDR_WIDTH-1:0]  oWriteAddress,
    output logic [INSTR_WIDTH-1:0] oWriteData,
    output logic                   oCpuHold,
    output logic                   oDone,
    output logic                   oError
);

    state_t                state_reg, state_next;
    logic [15:0]           len_reg;
    logic [15:0]           written_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  xfer;
    logic                  start_load;
    logic                  last_byte;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]            sum_reg;
`endif

    assign xfer       = iByteValid && oByteReady;
    assign start_load = iStart && (state_reg == IDLE || state_reg == DONE || state_reg == ERROR);

    instr_assembler #(
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_asm (
        .clk       (Clock),
        .srst      (Reset),
        .clear     (start_load),
        .shift_en  (xfer && (state_reg == COLLECT)),
        .byte_in   (iByte),
        .word      (oWriteData),
        .last_byte (last_byte)
    );

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; iStart only matters when no load is in progress
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERROR: if (iStart) state_next = LEN_HI;
            LEN_HI:            if (xfer) state_next = LEN_LO;
            LEN_LO:            if (xfer) state_next = ({len_reg[15:8], iByte} == 16'd0) ? CHECK : COLLECT;
            COLLECT:           if (last_byte) state_next = WRITE;
            WRITE:             state_next = (({1'b0, written_reg} + 17'd1) < {1'b0, len_reg}) ? COLLECT : CHECK;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK:             if (xfer) state_next = (iByte == sum_reg) ? DONE : ERROR;
`else
            CHECK:             state_next = DONE;
`endif
            default:           state_next = IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        oByteReady   = 1'b0;
        oWriteEnable = 1'b0;
        oCpuHold     = 1'b0;
        oDone        = 1'b0;
        oError       = 1'b0;
        case (state_reg)
            LEN_HI, LEN_LO, COLLECT: begin
                oByteReady = 1'b1;
                oCpuHold   = 1'b1;
            end
            WRITE: begin
                oWriteEnable = 1'b1;
                oCpuHold     = 1'b1;
            end
            CHECK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                oByteReady = 1'b1;
`endif
                oCpuHold   = 1'b1;
            end
            DONE:  oDone = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ERROR: oError = 1'b1;
`endif
            default: ;
        endcase
    end

    // Length capture, write counter, address and running checksum
    always_ff @(posedge Clock) begin
        if (Reset || start_load) begin
            len_reg     <= '0;
            written_reg <= '0;
            addr_reg    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_reg     <= '0;
`endif
        end else begin
            if (xfer && state_reg == LEN_HI) len_reg[15:8] <= iByte;
            if (xfer && state_reg == LEN_LO) len_reg[7:0]  <= iByte;
            if (state_reg == WRITE) begin
                written_reg <= written_reg + 16'd1;
                addr_reg    <= addr_reg + ADDR_WIDTH'(1);   // wraps silently
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (xfer && state_reg != CHECK) sum_reg <= sum_reg + iByte;
`endif
        end
    end

    assign oWriteAddress = addr_reg;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: loads push expected writes into a
// queue, a monitor pops and compares on every write strobe.
module tb_program_loader;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iStart;
    logic        iByteValid;
    logic [7:0]  iByte;
    logic        oByteReady;
    logic        oWriteEnable;
    logic [15:0] oWriteAddress;
    logic [27:0] oWriteData;
    logic        oCpuHold;
    logic        oDone;
    logic        oError;

    program_loader dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iStart        (iStart),
        .iByteValid    (iByteValid),
        .iByte         (iByte),
        .oByteReady    (oByteReady),
        .oWriteEnable  (oWriteEnable),
        .oWriteAddress (oWriteAddress),
        .oWriteData    (oWriteData),
        .oCpuHold      (oCpuHold),
        .oDone         (oDone),
        .oError        (oError)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [15:0] addr;
        logic [27:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         exp_e;
    int          total = 0;
    int          bad = 0;
    int          writes_seen = 0;
    logic        prev_we = 1'b0;
    logic [7:0]  run_sum;
    bit          use_gaps;
    logic [31:0] wbuf [0:3];
    logic [27:0] ebuf [0:3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare every write strobe against the scoreboard
    always @(negedge Clock) begin
        if (oWriteEnable === 1'b1) begin
            writes_seen++;
            check("we_one_cycle", {63'd0, prev_we}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'd1, 64'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("wr_addr", {48'd0, oWriteAddress}, {48'd0, exp_e.addr});
                check("wr_data", {36'd0, oWriteData}, {36'd0, exp_e.data});
            end
            $display("write addr=%0h data=%0h", oWriteAddress, oWriteData);
        end
        prev_we = oWriteEnable;
    end

    // Offer one byte; called and returns aligned to a falling edge
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        if (use_gaps) begin
            repeat ($urandom_range(0, 3)) begin
                iByte = 8'($urandom);
                @(negedge Clock);
            end
        end
        iByte      = b;
        iByteValid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (oByteReady) begin
                ok = 1'b1;
                @(negedge Clock);
                break;
            end
            @(negedge Clock);
        end
        iByteValid = 1'b0;
        if (!ok) check("byte_accept_timeout", 64'd0, 64'd1);
        run_sum = run_sum + b;
    endtask

    task automatic pulse_start();
        iStart = 1'b1;
        @(negedge Clock);
        iStart = 1'b0;
    endtask

    // Full load of n words from wbuf, expecting ebuf at addresses 0..n-1
    task automatic do_load(input string tag, input int n, input bit gaps,
                           input bit mid_start, input bit bad_sum, input bit exp_err);
        int   ws0;
        logic [31:0] w;
        ws0      = writes_seen;
        run_sum  = 8'd0;
        use_gaps = gaps;
        pulse_start();
        check({tag, "_hold_loading"}, {63'd0, oCpuHold}, 64'd1);
        check({tag, "_done_cleared"}, {63'd0, oDone}, 64'd0);
        send_byte(8'(n >> 8));
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            w = wbuf[i];
            exp_q.push_back({16'(i), ebuf[i]});
            for (int b = 0; b < 4; b++) begin
                send_byte(w[31-8*b -: 8]);
                if (mid_start && i == 0 && b == 1) pulse_start();
            end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(bad_sum ? run_sum - 8'd1 : run_sum);
`endif
        for (int k = 0; k < 40; k++) begin
            if (oDone || oError) break;
            @(negedge Clock);
        end
        check({tag, "_done"}, {63'd0, oDone}, {63'd0, !exp_err});
        check({tag, "_error"}, {63'd0, oError}, {63'd0, exp_err});
        check({tag, "_hold_released"}, {63'd0, oCpuHold}, 64'd0);
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_write_count"}, 64'(writes_seen - ws0), 64'(n));
        $display("load %s n=%0d done=%0b error=%0b", tag, n, oDone, oError);
        use_gaps = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, {63'd0, oByteReady}, 64'd0);
        check({tag, "_we"}, {63'd0, oWriteEnable}, 64'd0);
        check({tag, "_addr"}, {48'd0, oWriteAddress}, 64'd0);
        check({tag, "_data"}, {36'd0, oWriteData}, 64'd0);
        check({tag, "_hold"}, {63'd0, oCpuHold}, 64'd0);
        check({tag, "_done"}, {63'd0, oDone}, 64'd0);
        check({tag, "_error"}, {63'd0, oError}, 64'd0);
    endtask

    initial begin
        int ws0;
        Reset = 1'b1; iStart = 1'b0; iByteValid = 1'b0; iByte = 8'd0;
        use_gaps = 1'b0; run_sum = 8'd0;
        repeat (3) @(negedge Clock);
        check_all_zero("reset");
        Reset = 1'b0;
        @(negedge Clock);

        // Basic two-word load
        wbuf[0] = 32'h0A004000; ebuf[0] = 28'hA004000;
        wbuf[1] = 32'h01234567; ebuf[1] = 28'h1234567;
        do_load("basic", 2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Same data with iByteValid toggled randomly
        do_load("gaps", 2, 1'b1, 1'b0, 1'b0, 1'b0);

        // Empty program
        do_load("empty", 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Upper nibble of each group discarded
        wbuf[0] = 32'hFFFFFFFF; ebuf[0] = 28'hFFFFFFF;
        wbuf[1] = 32'hF0000001; ebuf[1] = 28'h0000001;
        wbuf[2] = 32'h5ABCDEF0; ebuf[2] = 28'hABCDEF0;
        do_load("nibble", 3, 1'b1, 1'b0, 1'b0, 1'b0);

        // iStart during a load is ignored
        wbuf[0] = 32'h0A004000; ebuf[0] = 28'hA004000;
        wbuf[1] = 32'h01234567; ebuf[1] = 28'h1234567;
        do_load("midstart", 2, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Wrong checksum (0x05 against a sum of 0x06)
        wbuf[0] = 32'h00000005; ebuf[0] = 28'h0000005;
        do_load("badsum", 1, 1'b0, 1'b0, 1'b1, 1'b1);
`endif

        // Reset after two of four instruction bytes
        ws0 = writes_seen;
        run_sum = 8'd0;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAB);
        send_byte(8'hCD);
        Reset = 1'b1;
        @(negedge Clock);
        check_all_zero("midreset");
        Reset = 1'b0;
        repeat (10) @(negedge Clock);
        check("midreset_no_write", 64'(writes_seen - ws0), 64'd0);
        check("midreset_idle_done", {63'd0, oDone}, 64'd0);
        $display("load midreset writes=%0d", writes_seen - ws0);

        // Normal load works after the aborted one
        do_load("after_reset", 2, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 28, instruction word width written to program memory.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, program memory address width.
REQ-003 SHALL have port Clock, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port iStart, input, 1, single-cycle request to begin a load.
REQ-006 SHALL have port iByteValid, input, 1, iByte holds a valid byte.
REQ-007 SHALL have port iByte, input, 8, incoming byte stream.
REQ-008 SHALL have port oByteReady, output, 1, loader accepts a byte this cycle.
REQ-009 SHALL have port oWriteEnable, output, 1, one-cycle program memory write strobe.
REQ-010 SHALL have port oWriteAddress, output, ADDR_WIDTH, write address.
REQ-011 SHALL have port oWriteData, output, INSTR_WIDTH, instruction word to write.
REQ-012 SHALL have port oCpuHold, output, 1, holds the CPU in reset while loading.
REQ-013 SHALL have port oDone, output, 1, load completed successfully.
REQ-014 SHALL have port oError, output, 1, load failed.

Function
REQ-015 SHALL transfer a byte only on a cycle with iByteValid and oByteReady both high.
REQ-016 SHALL use states IDLE, LEN_HI, LEN_LO, COLLECT, WRITE, CHECK, DONE, ERROR.
REQ-017 SHALL go from IDLE, DONE or ERROR to LEN_HI on iStart, clearing oDone, oError, address, byte counter and sum, and asserting oCpuHold.
REQ-018 SHALL ignore iStart in every other state.
REQ-019 SHALL accept the 16-bit word count N MSB first: LEN_HI then LEN_LO.
REQ-020 SHALL go directly to CHECK when N is 0; otherwise it SHALL go to COLLECT.
REQ-021 SHALL collect 4 bytes per instruction MSB first in COLLECT, then SHALL go to WRITE.
REQ-022 SHALL keep the low INSTR_WIDTH bits of each 32-bit group and discard the upper 4 bits.
REQ-023 SHALL assert oWriteEnable for exactly one cycle in WRITE, with oWriteData and oWriteAddress stable that cycle.
REQ-024 SHALL hold oByteReady low in WRITE, CHECK's exit cycle, IDLE, DONE and ERROR.
REQ-025 SHALL start at address 0 and SHALL increment the address by 1 after each write.
REQ-026 SHALL return to COLLECT after a write while written < N, else SHALL go to CHECK.
REQ-027 SHALL let the address wrap from 2^ADDR_WIDTH-1 to 0 without error.
REQ-028 SHALL drive oCpuHold high from LEN_HI until it enters DONE or ERROR.
REQ-029 SHALL latch oDone in DONE and oError in ERROR until the next iStart or Reset.
REQ-030 SHALL have no timeout; it SHALL stall indefinitely while iByteValid is low.

Reset
REQ-031 SHALL on Reset enter IDLE and clear oByteReady, oWriteEnable, oWriteAddress, oWriteData, oCpuHold, oDone, oError, counters and sum, including mid-load; no partial word is written.

Configuration
REQ-032 SHALL, with macro PROGRAM_LOADER_CHECKSUM_EN defined, keep an 8-bit modulo-256 sum of all length and instruction bytes.
REQ-033 SHALL, with the macro defined, accept one checksum byte in CHECK, going to DONE when it equals the sum and to ERROR otherwise.
REQ-034 SHALL, without the macro, go from CHECK to DONE in one cycle without consuming a byte, and SHALL tie oError to 0.

Structure
REQ-035 SHALL keep state encodings and the bytes-per-instruction constant (4) in the shared definitions header used with the opcode defines.
REQ-036 SHALL place the shift-in register and byte counter in a sub-module instr_assembler.

Verification
REQ-037 SHALL verify N=2, bytes 0x0A,0x00,0x40,0x00 then 0x01,0x23,0x45,0x67 -> writes 0xA004000@0 and 0x1234567@1, each strobe 1 cycle, then oDone=1 and oCpuHold=0.
REQ-038 SHALL verify N=0 -> no oWriteEnable; CHECK, then DONE; with the macro, checksum byte 0x00 is required.
REQ-039 SHALL verify, with the macro, N=1 with data 0x00,0x00,0x00,0x05 and checksum 0x05 -> oError=1, oDone=0, one write.
REQ-040 SHALL verify Reset asserted after 2 of 4 instruction bytes -> IDLE next cycle, all outputs 0, and no write.
REQ-041 SHALL verify iByteValid toggled randomly -> identical written data, and byte transfers only when oByteReady is high.
REQ-042 SHALL verify iStart pulsed mid-load -> ignored; the load completes normally.
